pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter HIGH_CYCLES, default 4: cycles oSig is held high per trigger; legal range >= 1.
REQ-002 Parameter GAP_CYCLES, default 2: forced low cycles after each high interval; legal range >= 1.
REQ-003 Parameter MAX_PENDING, default 3: depth of the queued-trigger counter; legal range >= 1.
REQ-004 iClk  input  1  sole clock; all state updates on its rising edge.
REQ-005 iRst  input  1  reset, synchronous, active-high.
REQ-006 iSig  input  1  trigger; each cycle sampled high counts as one trigger (one-cycle pulses from posedge detection intended).
REQ-007 oSig  output  1  stretched level, registered.
REQ-008 oBusy  output  1  high whenever state is not IDLE, registered.
REQ-009 oPending  output  clog2(MAX_PENDING+1)  current queued-trigger count.
REQ-010 oOverflow  output  1  one-cycle pulse: a trigger was dropped because the queue was full.

Function
REQ-011 States SHALL be IDLE, HIGH and GAP; oSig = 1 exactly when state is HIGH.
REQ-012 IDLE with iSig=1 SHALL enter HIGH next cycle with the cycle counter loaded; pending stays unchanged.
REQ-013 HIGH SHALL last exactly HIGH_CYCLES cycles, then enter GAP.
REQ-014 GAP SHALL last exactly GAP_CYCLES cycles; on its last cycle, if pending>0 or iSig=1, the next state SHALL be HIGH, otherwise IDLE.
REQ-015 Pending update per cycle: +1 for an iSig=1 not consumed by an IDLE->HIGH or GAP->HIGH transition; -1 when a GAP->HIGH transition consumes a queued trigger; both may occur in the same cycle (net 0).
REQ-016 On the last GAP cycle with iSig=1 and pending=0, the trigger SHALL be consumed directly; pending stays 0.
REQ-017 A trigger in HIGH or GAP with pending=MAX_PENDING and no consumption that cycle SHALL be dropped, and oOverflow SHALL be 1 in the following cycle only.
REQ-018 Pending SHALL saturate at MAX_PENDING and never wrap below 0.
REQ-019 Cycle counter width SHALL be clog2(max(HIGH_CYCLES,GAP_CYCLES)+1); HIGH_CYCLES=1 and GAP_CYCLES=1 SHALL produce single-cycle phases.
REQ-020 Latency from trigger sampled in IDLE to oSig=1 SHALL be exactly 1 cycle.

Reset
REQ-021 iRst=1 SHALL, at the next edge, force state IDLE, counter 0, pending 0, oSig 0, oBusy 0, oOverflow 0, regardless of state.
REQ-022 iSig in a cycle where iRst=1 SHALL be ignored; reset mid-HIGH or mid-GAP discards all queued triggers.

Structure
REQ-023 State encoding localparams (IDLE, HIGH, GAP) SHALL reside in the shared game-constants package/include, alongside the default HIGH/GAP/MAX values.
REQ-024 A down-counter sub-module, phase_counter (load value, enable, zero flag), is the natural split; the FSM and pending counter stay in pulse_stretcher.

Verification (defaults 4/2/3; cycle n = nth edge after reset release)
REQ-025 Single pulse at cycle 0 -> oSig=1 cycles 1-4, 0 cycles 5-6, oBusy=0 from cycle 7, oPending=0 throughout.
REQ-026 Pulses at cycles 0 and 2 -> oPending=1 cycles 3-6; second high cycles 7-10, gap 11-12, oPending=0 from 7.
REQ-027 Pulses at cycles 0-4 -> oPending reaches 3 at cycle 4; trigger at cycle 4 dropped, oOverflow=1 at cycle 5 only; four high intervals total.
REQ-028 Single pulse at cycle 0, second pulse at cycle 6 (last gap cycle) -> oSig high cycles 7-10, oPending stays 0.
REQ-029 Pulses at cycles 0,1,2, iRst=1 and iSig=1 at cycle 3 -> at cycle 4 oSig=0, oBusy=0, oPending=0; no further output.
REQ-030 iSig held high cycles 0-2 from IDLE -> three back-to-back high intervals (1-4, 7-10, 13-16), oPending peaks at 2.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared constants for the pulse stretcher.
// Holds the FSM state encoding, the default phase lengths and queue depth,
// and a small max() helper that is used to size the phase counter.
package pulse_stretcher_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_HIGH = 2'd1;
  localparam logic [1:0] STATE_GAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_HIGH = STATE_HIGH,
    ST_GAP  = STATE_GAP
  } state_e;

  localparam int unsigned DEFAULT_HIGH_CYCLES = 4;
  localparam int unsigned DEFAULT_GAP_CYCLES  = 2;
  localparam int unsigned DEFAULT_MAX_PENDING = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_phase_counter.sv
// Down-counter that times one FSM phase.
// Ports:
//   clk        clock
//   srst       synchronous active-high reset, clears the count
//   load       load load_value this cycle (has priority over enable)
//   load_value value loaded; a phase of N cycles is loaded with N-1
//   enable     decrement by one (holds at zero)
//   zero       high when the current count is zero, i.e. last phase cycle
module phase_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: every trigger on iSig produces a HIGH_CYCLES-long high
// interval on oSig followed by GAP_CYCLES forced low. Triggers arriving while
// busy are queued in a saturating counter (depth MAX_PENDING); a trigger that
// finds the queue full is dropped and flagged on oOverflow for one cycle.
// Ports:
//   iClk      clock
//   iRst      synchronous active-high reset
//   iSig      trigger, one trigger per cycle sampled high
//   oSig      stretched output, high exactly while in HIGH (registered)
//   oBusy     high whenever not IDLE (registered)
//   oPending  number of queued triggers
//   oOverflow one-cycle pulse after a trigger was dropped
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int unsigned MAX_PENDING = DEFAULT_MAX_PENDING
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic                             iSig,
  output logic                             oSig,
  output logic                             oBusy,
  output logic [$clog2(MAX_PENDING+1)-1:0] oPending,
  output logic                             oOverflow
);

  localparam int unsigned CNT_W  = $clog2(max_u(HIGH_CYCLES, GAP_CYCLES) + 1);
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  state_e              state_q, state_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic                sig_q, sig_d;
  logic                busy_q, busy_d;

  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_load_value;
  logic                cnt_enable;
  logic                cnt_zero;

  // consume_direct: this cycle's iSig starts the next high interval itself.
  // consume_queued: a queued trigger starts the next high interval.
  logic                consume_direct;
  logic                consume_queued;
  logic                queue_trig;

  phase_counter #(
    .WIDTH(CNT_W)
  ) u_phase_counter (
    .clk        (iClk),
    .srst       (iRst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (cnt_enable),
    .zero       (cnt_zero)
  );

  // Next state and phase-counter control
  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_enable     = 1'b0;
    consume_direct = 1'b0;
    consume_queued = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iSig) begin
          state_d        = ST_HIGH;
          cnt_load       = 1'b1;
          cnt_load_value = CNT_W'(HIGH_CYCLES - 1);
          consume_direct = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          state_d        = ST_GAP;
          cnt_load       = 1'b1;
          cnt_load_value = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_enable = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          // Queued triggers are older than the current one, so they go first;
          // a concurrent iSig then simply takes the freed queue slot.
          if (pending_q != '0) begin
            state_d        = ST_HIGH;
            cnt_load       = 1'b1;
            cnt_load_value = CNT_W'(HIGH_CYCLES - 1);
            consume_queued = 1'b1;
          end else if (iSig) begin
            state_d        = ST_HIGH;
            cnt_load       = 1'b1;
            cnt_load_value = CNT_W'(HIGH_CYCLES - 1);
            consume_direct = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_enable = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending queue update and overflow detection
  always_comb begin
    pending_d  = pending_q;
    overflow_d = 1'b0;
    queue_trig = iSig && !consume_direct;
    if (queue_trig && !consume_queued) begin
      if (pending_q == PEND_W'(MAX_PENDING)) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_W'(1);
      end
    end else if (!queue_trig && consume_queued) begin
      pending_d = pending_q - PEND_W'(1);
    end
  end

  // Outputs are registered from the next state so they line up with state_q
  always_comb begin
    sig_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      sig_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      sig_q      <= sig_d;
      busy_q     <= busy_d;
    end
  end

  assign oSig      = sig_q;
  assign oBusy     = busy_q;
  assign oPending  = pending_q;
  assign oOverflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed testbench for pulse_stretcher. Two instances share the stimulus:
// dut uses the defaults (4/2/3), dut_min uses the minimum legal 1/1/1.
// Cycle n is the period following the nth clock edge after reset release;
// the value driven on iSig in cycle n is sampled at the edge that ends it.
module tb_pulse_stretcher;

  logic       iClk;
  logic       iRst;
  logic       iSig;
  logic       oSig, oBusy, oOverflow;
  logic [1:0] oPending;
  logic       m_sig, m_busy, m_ovf;
  logic [0:0] m_pend;

  int checks;
  int failures;

  int obs_sig  [0:31];
  int obs_busy [0:31];
  int obs_pend [0:31];
  int obs_ovf  [0:31];
  int min_sig  [0:31];
  int min_busy [0:31];
  int min_pend [0:31];
  int min_ovf  [0:31];

  pulse_stretcher dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iSig      (iSig),
    .oSig      (oSig),
    .oBusy     (oBusy),
    .oPending  (oPending),
    .oOverflow (oOverflow)
  );

  pulse_stretcher #(
    .HIGH_CYCLES(1),
    .GAP_CYCLES (1),
    .MAX_PENDING(1)
  ) dut_min (
    .iClk      (iClk),
    .iRst      (iRst),
    .iSig      (iSig),
    .oSig      (m_sig),
    .oBusy     (m_busy),
    .oPending  (m_pend),
    .oOverflow (m_ovf)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reset with iSig held high to show triggers are ignored during reset.
  task automatic do_reset();
    iRst = 1'b1;
    iSig = 1'b1;
    @(posedge iClk);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    iSig = 1'b0;
  endtask

  task automatic sample(input int n);
    obs_sig[n]  = int'(oSig);
    obs_busy[n] = int'(oBusy);
    obs_pend[n] = int'(oPending);
    obs_ovf[n]  = int'(oOverflow);
    min_sig[n]  = int'(m_sig);
    min_busy[n] = int'(m_busy);
    min_pend[n] = int'(m_pend);
    min_ovf[n]  = int'(m_ovf);
  endtask

  // Drive trig[n]/rst[n] during cycle n and record outputs for cycles 0..ncyc.
  task automatic run(input logic [31:0] trig, input logic [31:0] rst, input int ncyc);
    sample(0);
    for (int n = 0; n < ncyc; n++) begin
      iSig = trig[n];
      iRst = rst[n];
      @(posedge iClk);
      #1;
      sample(n + 1);
    end
    iSig = 1'b0;
    iRst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (oSig !== 1'b0 || oBusy !== 1'b0 || oPending !== 2'd0 || oOverflow !== 1'b0) begin
      $display("FAIL reset_state got sig=%b busy=%b pend=%0d ovf=%b exp all zero",
               oSig, oBusy, oPending, oOverflow);
      failures++;
    end
    checks++;
    if (m_sig !== 1'b0 || m_busy !== 1'b0 || m_pend !== 1'b0 || m_ovf !== 1'b0) begin
      $display("FAIL reset_state_min got sig=%b busy=%b pend=%0d ovf=%b exp all zero",
               m_sig, m_busy, m_pend, m_ovf);
      failures++;
    end
    checks++;
    $display("test_reset: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single();
    logic [31:0] exp_sig, exp_busy;
    exp_sig  = 32'h0000_001E;  // 1-4
    exp_busy = 32'h0000_007E;  // 1-6
    do_reset();
    run(32'h1, 32'h0, 12);
    for (int n = 0; n <= 12; n++) begin
      if (obs_sig[n] !== int'(exp_sig[n])) begin
        $display("FAIL single_sig cyc=%0d got=%0d exp=%0d", n, obs_sig[n], exp_sig[n]); failures++;
      end
      if (obs_busy[n] !== int'(exp_busy[n])) begin
        $display("FAIL single_busy cyc=%0d got=%0d exp=%0d", n, obs_busy[n], exp_busy[n]); failures++;
      end
      if (obs_pend[n] !== 0) begin
        $display("FAIL single_pend cyc=%0d got=%0d exp=0", n, obs_pend[n]); failures++;
      end
      if (obs_ovf[n] !== 0) begin
        $display("FAIL single_ovf cyc=%0d got=%0d exp=0", n, obs_ovf[n]); failures++;
      end
      checks += 4;
    end
    $display("test_single: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_sig, exp_busy;
    int ep;
    exp_sig  = 32'h0000_079E;  // 1-4, 7-10
    exp_busy = 32'h0000_1FFE;  // 1-12
    do_reset();
    run(32'h5, 32'h0, 18);
    for (int n = 0; n <= 18; n++) begin
      ep = (n >= 3 && n <= 6) ? 1 : 0;
      if (obs_sig[n] !== int'(exp_sig[n])) begin
        $display("FAIL b2b_sig cyc=%0d got=%0d exp=%0d", n, obs_sig[n], exp_sig[n]); failures++;
      end
      if (obs_busy[n] !== int'(exp_busy[n])) begin
        $display("FAIL b2b_busy cyc=%0d got=%0d exp=%0d", n, obs_busy[n], exp_busy[n]); failures++;
      end
      if (obs_pend[n] !== ep) begin
        $display("FAIL b2b_pend cyc=%0d got=%0d exp=%0d", n, obs_pend[n], ep); failures++;
      end
      if (obs_ovf[n] !== 0) begin
        $display("FAIL b2b_ovf cyc=%0d got=%0d exp=0", n, obs_ovf[n]); failures++;
      end
      checks += 4;
    end
    $display("test_back_to_back: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_overflow();
    logic [31:0] exp_sig;
    int ep, eb, eo;
    exp_sig = 32'h0079_E79E;  // 1-4, 7-10, 13-16, 19-22
    do_reset();
    run(32'h1F, 32'h0, 28);
    for (int n = 0; n <= 28; n++) begin
      ep = (n == 2) ? 1 : (n == 3) ? 2 : (n >= 4 && n <= 6) ? 3 :
           (n >= 7 && n <= 12) ? 2 : (n >= 13 && n <= 18) ? 1 : 0;
      eb = (n >= 1 && n <= 24) ? 1 : 0;
      eo = (n == 5) ? 1 : 0;
      if (obs_sig[n] !== int'(exp_sig[n])) begin
        $display("FAIL ovf_sig cyc=%0d got=%0d exp=%0d", n, obs_sig[n], exp_sig[n]); failures++;
      end
      if (obs_busy[n] !== eb) begin
        $display("FAIL ovf_busy cyc=%0d got=%0d exp=%0d", n, obs_busy[n], eb); failures++;
      end
      if (obs_pend[n] !== ep) begin
        $display("FAIL ovf_pend cyc=%0d got=%0d exp=%0d", n, obs_pend[n], ep); failures++;
      end
      if (obs_ovf[n] !== eo) begin
        $display("FAIL ovf_flag cyc=%0d got=%0d exp=%0d", n, obs_ovf[n], eo); failures++;
      end
      checks += 4;
    end
    $display("test_overflow: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_last_gap();
    logic [31:0] exp_sig, exp_busy;
    exp_sig  = 32'h0000_079E;  // 1-4, 7-10
    exp_busy = 32'h0000_1FFE;  // 1-12
    do_reset();
    run(32'h41, 32'h0, 16);
    for (int n = 0; n <= 16; n++) begin
      if (obs_sig[n] !== int'(exp_sig[n])) begin
        $display("FAIL lastgap_sig cyc=%0d got=%0d exp=%0d", n, obs_sig[n], exp_sig[n]); failures++;
      end
      if (obs_busy[n] !== int'(exp_busy[n])) begin
        $display("FAIL lastgap_busy cyc=%0d got=%0d exp=%0d", n, obs_busy[n], exp_busy[n]); failures++;
      end
      if (obs_pend[n] !== 0) begin
        $display("FAIL lastgap_pend cyc=%0d got=%0d exp=0", n, obs_pend[n]); failures++;
      end
      checks += 3;
    end
    $display("test_last_gap: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(32'hF, 32'h8, 12);
    if (obs_pend[3] !== 2) begin
      $display("FAIL rstmid_pend_before got=%0d exp=2", obs_pend[3]); failures++;
    end
    checks++;
    for (int n = 4; n <= 12; n++) begin
      if (obs_sig[n] !== 0 || obs_busy[n] !== 0 || obs_pend[n] !== 0 || obs_ovf[n] !== 0) begin
        $display("FAIL rstmid_after cyc=%0d got sig=%0d busy=%0d pend=%0d ovf=%0d exp all 0",
                 n, obs_sig[n], obs_busy[n], obs_pend[n], obs_ovf[n]);
        failures++;
      end
      checks++;
    end
    $display("test_reset_mid: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_held();
    logic [31:0] exp_sig;
    int ep, eb;
    exp_sig = 32'h0001_E79E;  // 1-4, 7-10, 13-16
    do_reset();
    run(32'h7, 32'h0, 22);
    for (int n = 0; n <= 22; n++) begin
      ep = (n == 2) ? 1 : (n >= 3 && n <= 6) ? 2 : (n >= 7 && n <= 12) ? 1 : 0;
      eb = (n >= 1 && n <= 18) ? 1 : 0;
      if (obs_sig[n] !== int'(exp_sig[n])) begin
        $display("FAIL held_sig cyc=%0d got=%0d exp=%0d", n, obs_sig[n], exp_sig[n]); failures++;
      end
      if (obs_busy[n] !== eb) begin
        $display("FAIL held_busy cyc=%0d got=%0d exp=%0d", n, obs_busy[n], eb); failures++;
      end
      if (obs_pend[n] !== ep) begin
        $display("FAIL held_pend cyc=%0d got=%0d exp=%0d", n, obs_pend[n], ep); failures++;
      end
      if (obs_ovf[n] !== 0) begin
        $display("FAIL held_ovf cyc=%0d got=%0d exp=0", n, obs_ovf[n]); failures++;
      end
      checks += 4;
    end
    $display("test_held: checks=%0d failures=%0d", checks, failures);
  endtask

  // 1/1/1 instance: single-cycle phases, queue of one, net-zero update on the
  // last gap cycle, and overflow when the single slot is full.
  task automatic test_min_params();
    logic [31:0] exp_sig, exp_busy, exp_pend, exp_ovf;
    exp_sig  = 32'h0000_002A;  // 1, 3, 5
    exp_busy = 32'h0000_007E;  // 1-6
    exp_pend = 32'h0000_001C;  // 2-4
    exp_ovf  = 32'h0000_0010;  // 4
    do_reset();
    run(32'hF, 32'h0, 10);
    for (int n = 0; n <= 10; n++) begin
      if (min_sig[n] !== int'(exp_sig[n])) begin
        $display("FAIL min_sig cyc=%0d got=%0d exp=%0d", n, min_sig[n], exp_sig[n]); failures++;
      end
      if (min_busy[n] !== int'(exp_busy[n])) begin
        $display("FAIL min_busy cyc=%0d got=%0d exp=%0d", n, min_busy[n], exp_busy[n]); failures++;
      end
      if (min_pend[n] !== int'(exp_pend[n])) begin
        $display("FAIL min_pend cyc=%0d got=%0d exp=%0d", n, min_pend[n], exp_pend[n]); failures++;
      end
      if (min_ovf[n] !== int'(exp_ovf[n])) begin
        $display("FAIL min_ovf cyc=%0d got=%0d exp=%0d", n, min_ovf[n], exp_ovf[n]); failures++;
      end
      checks += 4;
    end
    $display("test_min_params: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    iRst     = 1'b1;
    iSig     = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_last_gap();
    test_reset_mid();
    test_held();
    test_min_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
